// File: rtl/new_all_taps_pkg.sv
// new_all_taps_pkg: shared types, default sizes and the coefficient formula
// for the tap-coefficient sequencer.
package new_all_taps_pkg;

  localparam int DEFAULT_NUM_TAPS = 4;
  localparam int DEFAULT_COEFF_W  = 16;

  typedef logic [DEFAULT_COEFF_W-1:0] coeff_t;

  // coeff(e,k) = (e << 8) + (2*numTaps - 1 - k), full 32-bit result;
  // callers truncate to their coefficient width.
  function automatic logic [31:0] tap_coeff(input logic [7:0]  e,
                                            input logic [8:0]  k,
                                            input int unsigned numTaps);
    logic [31:0] base;
    logic [31:0] offs;
    base = {16'd0, e, 8'd0};
    offs = 32'(2 * numTaps - 1) - {23'd0, k};
    return base + offs;
  endfunction

endpackage

// File: rtl/new_all_taps_rom.sv
// new_all_taps_rom: combinational coefficient lookup (setting, tap) -> coeff.
// Kept as its own block so it can later become a memory-initialised table.
module new_all_taps_rom
  import new_all_taps_pkg::*;
#(
  parameter int NUM_TAPS = DEFAULT_NUM_TAPS,
  parameter int COEFF_W  = DEFAULT_COEFF_W,
  parameter int CNT_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
  input  logic [7:0]         eSel,
  input  logic [CNT_W-1:0]   tapIdx,
  output logic [COEFF_W-1:0] coeff
);

  logic [31:0] fullCoeff;

  // Evaluate the formula and truncate to the coefficient width.
  always_comb begin
    fullCoeff = tap_coeff(eSel, 9'(tapIdx), NUM_TAPS);
    coeff     = fullCoeff[COEFF_W-1:0];
  end

endmodule

// File: rtl/new_all_taps.sv
// new_all_taps: free-running tap-coefficient sequencer. Every clock it emits
// one (tap index, coefficient) pair, sweeping taps 0..NUM_TAPS-1.
// The setting is latched at tap 0 so a sweep never mixes two settings.
// Optional macro NEW_ALL_TAPS_VEC_EN adds the allTaps register holding the
// whole coefficient set.
module new_all_taps
  import new_all_taps_pkg::*;
#(
  parameter int NUM_TAPS = DEFAULT_NUM_TAPS,
  parameter int COEFF_W  = DEFAULT_COEFF_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          eqVal,
  output logic [COEFF_W-1:0]  tapcoeff,
  output logic [7:0]          outputTapnum
`ifdef NEW_ALL_TAPS_VEC_EN
  ,
  output logic [NUM_TAPS*COEFF_W-1:0] allTaps
`endif
);

  localparam int CNT_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);

  logic [CNT_W-1:0]   tapCnt_q;
  logic [CNT_W-1:0]   tapCnt_d;
  logic [7:0]         eqCur_q;
  logic [7:0]         eqCur_d;
  logic [7:0]         eSel;
  logic [COEFF_W-1:0] coeffD;
  logic [COEFF_W-1:0] tapcoeff_q;
  logic [7:0]         outputTapnum_q;

  // Tap 0 samples the live setting; the rest of the sweep reuses it.
  always_comb begin
    eSel     = (tapCnt_q == '0) ? eqVal : eqCur_q;
    eqCur_d  = eSel;
    tapCnt_d = (tapCnt_q == LAST_TAP) ? '0 : tapCnt_q + 1'b1;
  end

  new_all_taps_rom #(
    .NUM_TAPS (NUM_TAPS),
    .COEFF_W  (COEFF_W),
    .CNT_W    (CNT_W)
  ) u_rom (
    .eSel   (eSel),
    .tapIdx (tapCnt_q),
    .coeff  (coeffD)
  );

  // Counter, held setting and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tapCnt_q       <= '0;
      eqCur_q        <= '0;
      tapcoeff_q     <= '0;
      outputTapnum_q <= '0;
    end else begin
      tapCnt_q       <= tapCnt_d;
      eqCur_q        <= eqCur_d;
      tapcoeff_q     <= coeffD;
      outputTapnum_q <= 8'(tapCnt_q);
    end
  end

  assign tapcoeff     = tapcoeff_q;
  assign outputTapnum = outputTapnum_q;

`ifdef NEW_ALL_TAPS_VEC_EN
  logic [NUM_TAPS*COEFF_W-1:0] allTaps_q;

  // Slot of the current tap is refreshed on the same edge as tapcoeff.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      allTaps_q <= '0;
    end else begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        if (tapCnt_q == CNT_W'(k)) begin
          allTaps_q[k*COEFF_W +: COEFF_W] <= coeffD;
        end
      end
    end
  end

  assign allTaps = allTaps_q;
`endif

endmodule

// File: tb/tb_new_all_taps.sv
// tb_new_all_taps: table-driven and scoreboard checks for new_all_taps
// (NUM_TAPS=4, COEFF_W=16). Covers NEW_ALL_TAPS_VEC_EN when defined.
module tb_new_all_taps;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   eqVal = 8'd0;
  logic [W-1:0] tapcoeff;
  logic [7:0]   outputTapnum;
`ifdef NEW_ALL_TAPS_VEC_EN
  logic [N*W-1:0] allTaps;
`endif

  new_all_taps #(.NUM_TAPS(N), .COEFF_W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .eqVal        (eqVal),
    .tapcoeff     (tapcoeff),
    .outputTapnum (outputTapnum)
`ifdef NEW_ALL_TAPS_VEC_EN
    ,
    .allTaps      (allTaps)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  eq;
    logic [7:0]  tap;
    logic [15:0] coeff;
  } vec_t;

  typedef struct {
    logic [7:0]  tap;
    logic [15:0] coeff;
  } exp_t;

  exp_t sbQ[$];
  vec_t vecs[18];
  int   total = 0;
  int   bad   = 0;
  int   modelCnt = 0;
  logic [7:0] modelEq = 8'd0;

  // Independent reference: (e << 8) + (2N-1-k), 16 bits.
  function automatic logic [15:0] refCoeff(input logic [7:0] e, input int k);
    logic [15:0] hi;
    hi = {e, 8'd0};
    return hi + 16'(2 * N - 1 - k);
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Drive the setting, queue the expected pair, advance one edge.
  task automatic applyStimulus(input logic [7:0] e, input logic [7:0] tap, input logic [15:0] c);
    exp_t x;
    eqVal   = e;
    x.tap   = tap;
    x.coeff = c;
    sbQ.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Same as applyStimulus but the expectation comes from the bench model.
  task automatic stepModel(input logic [7:0] e);
    logic [7:0] sel;
    sel = (modelCnt == 0) ? e : modelEq;
    if (modelCnt == 0) modelEq = e;
    applyStimulus(e, 8'(modelCnt), refCoeff(sel, modelCnt));
    modelCnt = (modelCnt + 1) % N;
  endtask

  task automatic checkOutput(input string name);
    exp_t x;
    total++;
    if (sbQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL %s: scoreboard empty, got tap=%0d coeff=%0h", name, outputTapnum, tapcoeff);
    end else begin
      total--;
      x = sbQ.pop_front();
      cmp({name, ".tap"}, 64'(outputTapnum), 64'(x.tap));
      cmp({name, ".coeff"}, 64'(tapcoeff), 64'(x.coeff));
    end
  endtask

  task automatic checkZero(input string name);
    cmp({name, ".tap"}, 64'(outputTapnum), 64'd0);
    cmp({name, ".coeff"}, 64'(tapcoeff), 64'd0);
`ifdef NEW_ALL_TAPS_VEC_EN
    cmp({name, ".allTaps"}, allTaps, 64'd0);
`endif
  endtask

  initial begin
    vecs[0]  = '{8'h00, 8'd0, 16'h0007};
    vecs[1]  = '{8'h00, 8'd1, 16'h0006};
    vecs[2]  = '{8'h00, 8'd2, 16'h0005};
    vecs[3]  = '{8'h00, 8'd3, 16'h0004};
    vecs[4]  = '{8'h00, 8'd0, 16'h0007};
    vecs[5]  = '{8'h03, 8'd1, 16'h0006};
    vecs[6]  = '{8'h03, 8'd2, 16'h0005};
    vecs[7]  = '{8'h03, 8'd3, 16'h0004};
    vecs[8]  = '{8'h03, 8'd0, 16'h0307};
    vecs[9]  = '{8'h03, 8'd1, 16'h0306};
    vecs[10] = '{8'h03, 8'd2, 16'h0305};
    vecs[11] = '{8'h03, 8'd3, 16'h0304};
    vecs[12] = '{8'h00, 8'd0, 16'h0007};
    vecs[13] = '{8'h00, 8'd1, 16'h0006};
    vecs[14] = '{8'h05, 8'd2, 16'h0005};
    vecs[15] = '{8'h05, 8'd3, 16'h0004};
    vecs[16] = '{8'h05, 8'd0, 16'h0507};
    vecs[17] = '{8'h05, 8'd1, 16'h0506};

    // Reset held across an edge: everything reads zero.
    #12;
    checkZero("reset_hold");

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].eq, vecs[i].tap, vecs[i].coeff);
      checkOutput($sformatf("vec%0d", i));
    end

    // Bring the model in line with the table's end state, show tap 2.
    modelCnt = 2;
    modelEq  = 8'h05;
    stepModel(8'h05);
    checkOutput("pre_reset_tap2");

    // Asynchronous reset mid-sweep: outputs clear before the next edge.
    #2;
    reset = 1'b1;
    #1;
    checkZero("async_reset");
    @(posedge clk);
    #1;
    checkZero("reset_edge");

    @(negedge clk);
    reset    = 1'b0;
    modelCnt = 0;
    modelEq  = 8'h00;

    // Restart plus wrap check over 2N+1 edges at eqVal=0.
    for (int i = 0; i < 2 * N + 1; i++) begin
      stepModel(8'h00);
      total++;
      if (outputTapnum > 8'(N - 1)) begin
        bad++;
        $display("[TB] FAIL wrap_range%0d: got tap %0d, expected <= %0d", i, outputTapnum, N - 1);
      end
      checkOutput($sformatf("wrap%0d", i));
`ifdef NEW_ALL_TAPS_VEC_EN
      if (i == N - 1 || i == 2 * N - 1)
        cmp($sformatf("allTaps%0d", i), allTaps, 64'h0004000500060007);
`endif
    end

    cmp("sb_drained", 64'(sbQ.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
